// File: rtl/multdiv_ctrl_pkg.sv
// rtl/multdiv_ctrl_pkg.sv - shared constants for the multdiv sequencer
package multdiv_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_RD_W           = 5;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// rtl/multdiv_ctrl_if.sv - request, multdiv and writeback signals of the sequencer
interface multdiv_ctrl_if #(parameter int RD_W = 5);

  logic            req_mult;
  logic            req_div;
  logic [31:0]     req_operandA;
  logic [31:0]     req_operandB;
  logic [RD_W-1:0] req_rd;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            ctrl_MULT;
  logic            ctrl_DIV;
  logic [31:0]     md_operandA;
  logic [31:0]     md_operandB;
  logic [31:0]     data_result;
  logic            data_exception;
  logic            data_resultRDY;
  logic            wb_valid;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_exception;

  modport master (
    output req_mult, req_div, req_operandA, req_operandB, req_rd, flush,
    output data_result, data_exception, data_resultRDY,
    input  stall, busy, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    input  wb_valid, wb_data, wb_rd, wb_exception
  );

  modport slave (
    input  req_mult, req_div, req_operandA, req_operandB, req_rd, flush,
    input  data_result, data_exception, data_resultRDY,
    output stall, busy, ctrl_MULT, ctrl_DIV, md_operandA, md_operandB,
    output wb_valid, wb_data, wb_rd, wb_exception
  );

endinterface

// File: rtl/multdiv_watchdog.sv
// rtl/multdiv_watchdog.sv - clear/enable counter flagging a hung multdiv
module multdiv_watchdog
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == TERM);

  // Saturates at the terminal count so tc stays asserted until cleared.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequences one mult/div op: start pulse, stall, writeback
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int RD_W           = DEFAULT_RD_W
) (
  input  logic         clock,
  input  logic         reset,
  multdiv_ctrl_if.slave bus
);

  logic [1:0]      state_q, state_d;
  logic            op_q, op_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic            wb_exc_q, wb_exc_d;
  logic            accept;
  logic            wd_clr;
  logic            wd_en;
  logic            wd_tc;

  // Reset gating keeps stall low while reset is held, even with a request pending.
  assign accept = !reset && ((state_q == IDLE) || (state_q == DONE)) &&
                  (bus.req_mult || bus.req_div) && !bus.flush;

  assign wd_en  = (state_q == BUSY);
  assign wd_clr = (state_q != BUSY) || bus.flush;

  multdiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock(clock),
    .reset(reset),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_exc_d  = wb_exc_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        state_d = bus.flush ? IDLE : BUSY;
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.data_resultRDY) begin
          state_d   = DONE;
          wb_data_d = bus.data_result;
          wb_exc_d  = bus.data_exception;
          wb_rd_d   = rd_q;
        end else if (wd_tc) begin
          state_d   = DONE;
          wb_data_d = '0;
          wb_exc_d  = 1'b1;
          wb_rd_d   = rd_q;
        end
      end
      default: begin
        state_d = accept ? START : IDLE;
      end
    endcase

    if (accept) begin
      op_d  = bus.req_mult ? OP_MULT : OP_DIV;
      opa_d = bus.req_operandA;
      opb_d = bus.req_operandB;
      rd_d  = bus.req_rd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_exc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_exc_q  <= wb_exc_d;
    end
  end

  assign bus.stall        = accept || (state_q == START) || (state_q == BUSY);
  assign bus.busy         = (state_q == START) || (state_q == BUSY);
  assign bus.ctrl_MULT    = (state_q == START) && (op_q == OP_MULT);
  assign bus.ctrl_DIV     = (state_q == START) && (op_q == OP_DIV);
  assign bus.md_operandA  = opa_q;
  assign bus.md_operandB  = opb_q;
  assign bus.wb_valid     = (state_q == DONE) && !bus.flush;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_exception = wb_exc_q;

endmodule
